// File: rtl/seq_pkg.sv
// Shared types for the vector sequencer: opcodes, control word, op classes,
// FSM state encoding and the opcode decode function.
package seq_pkg;

   localparam int unsigned SEQ_OP_W = 4;

   typedef enum logic [3:0] {
      OP_INC       = 4'b0001,
      OP_ADD       = 4'b0010,
      OP_CMP       = 4'b0011,
      OP_B         = 4'b0100,
      OP_BNQ       = 4'b0101,
      OP_LOAD_8X8  = 4'b0110,
      OP_STORE_8X8 = 4'b0111,
      OP_MODS_8X8  = 4'b1000,
      OP_INC1_4X16 = 4'b1001,
      OP_NORM_4X16 = 4'b1010,
      OP_MULS_4X16 = 4'b1011,
      OP_GET8X8    = 4'b1100,
      OP_MOV       = 4'b1110
   } op_e;

   typedef enum logic [1:0] {
      CLS_SCALAR,
      CLS_VECTOR,
      CLS_ILLEGAL
   } op_class_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_BUBBLE
   } seq_state_e;

   typedef struct packed {
      logic       get8;
      logic       pc_src;
      logic       scalar_write;
      logic       vector_write;
      logic       histogram_write;
      logic       mem_to_reg;
      logic       mem_write;
      logic       branch;
      logic       hist_src;
      logic       flag_write;
      logic       imm_src;
      logic       vector_or_histogram;
      logic [2:0] alu_control;
      logic [2:0] lane_control;
   } ctrl_word_t;

   typedef struct packed {
      op_class_e  cls;
      ctrl_word_t ctrl;
   } decode_t;

   localparam ctrl_word_t CTRL_NOP = '{
      get8: 1'b0, pc_src: 1'b0, scalar_write: 1'b0, vector_write: 1'b0,
      histogram_write: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0, branch: 1'b0,
      hist_src: 1'b0, flag_write: 1'b0, imm_src: 1'b0, vector_or_histogram: 1'b0,
      alu_control: 3'b011, lane_control: 3'b111
   };

   // Opcode to {class, control word}; fields not listed keep the NOP defaults.
   function automatic decode_t decode_op(input logic [SEQ_OP_W-1:0] op, input logic cond);
      decode_t d;
      d.cls  = CLS_SCALAR;
      d.ctrl = CTRL_NOP;
      case (op)
         OP_MOV: begin
            d.ctrl.scalar_write = 1'b1;
            d.ctrl.imm_src      = 1'b1;
            d.ctrl.alu_control  = 3'b100;
         end
         OP_INC: begin
            d.ctrl.scalar_write = 1'b1;
            d.ctrl.alu_control  = 3'b001;
         end
         OP_ADD: begin
            d.ctrl.scalar_write = 1'b1;
            d.ctrl.imm_src      = 1'b1;
            d.ctrl.alu_control  = 3'b000;
         end
         OP_CMP: begin
            d.ctrl.flag_write  = 1'b1;
            d.ctrl.alu_control = 3'b010;
         end
         OP_B: begin
            d.ctrl.branch      = 1'b1;
            d.ctrl.pc_src      = 1'b1;
            d.ctrl.imm_src     = 1'b1;
            d.ctrl.alu_control = 3'b100;
         end
         OP_BNQ: begin
            d.ctrl.branch      = 1'b1;
            d.ctrl.pc_src      = cond;
            d.ctrl.imm_src     = 1'b1;
            d.ctrl.alu_control = 3'b101;
         end
         OP_LOAD_8X8: begin
            d.cls                = CLS_VECTOR;
            d.ctrl.vector_write  = 1'b1;
            d.ctrl.mem_to_reg    = 1'b1;
         end
         OP_STORE_8X8: begin
            d.cls            = CLS_VECTOR;
            d.ctrl.mem_write = 1'b1;
         end
         OP_MODS_8X8: begin
            d.cls               = CLS_VECTOR;
            d.ctrl.vector_write = 1'b1;
         end
         OP_INC1_4X16: begin
            d.cls                      = CLS_VECTOR;
            d.ctrl.histogram_write     = 1'b1;
            d.ctrl.vector_or_histogram = 1'b1;
            d.ctrl.lane_control        = 3'b100;
         end
         OP_NORM_4X16: begin
            d.cls                      = CLS_VECTOR;
            d.ctrl.histogram_write     = 1'b1;
            d.ctrl.hist_src            = 1'b1;
            d.ctrl.vector_or_histogram = 1'b1;
            d.ctrl.lane_control        = 3'b000;
         end
         OP_MULS_4X16: begin
            d.cls                  = CLS_VECTOR;
            d.ctrl.histogram_write = 1'b1;
            d.ctrl.lane_control    = 3'b010;
         end
         OP_GET8X8: begin
            d.cls                      = CLS_VECTOR;
            d.ctrl.get8                = 1'b1;
            d.ctrl.vector_write        = 1'b1;
            d.ctrl.vector_or_histogram = 1'b1;
         end
         default: d.cls = CLS_ILLEGAL;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/lane_mask_gen.sv
// Beat index to lane mask: beat k enables lanes [k*LANES_PER_CYCLE +: LANES_PER_CYCLE].
//   beat_idx : current beat number
//   mask_c   : combinational lane mask for that beat
module lane_mask_gen #(
   parameter int unsigned NUM_LANES       = 8,
   parameter int unsigned LANES_PER_CYCLE = 4,
   localparam int unsigned BEATS          = NUM_LANES / LANES_PER_CYCLE,
   localparam int unsigned BW             = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic [BW-1:0]        beat_idx,
   output logic [NUM_LANES-1:0] mask_c
);

   always_comb begin
      mask_c = '0;
      for (int unsigned k = 0; k < BEATS; k++) begin
         if (beat_idx == BW'(k)) begin
            mask_c[k*LANES_PER_CYCLE +: LANES_PER_CYCLE] = '1;
         end
      end
   end

endmodule

// File: rtl/vector_sequencer.sv
// Multi-cycle opcode sequencer: accepts one opcode per handshake and issues a
// registered control word for one beat (scalar/branch) or BEATS beats (vector)
// with per-beat lane masks; honours datapath stall.
//   clk, reset             : clock, async active-high reset
//   instr_valid/ready, op, cond : instruction handshake (cond sampled at accept)
//   stall                  : holds the current beat
//   ctrl_valid, beat_idx, last_beat, lane_mask : beat framing
//   get8 .. lane_control   : control word fields
//   illegal_op             : one-cycle pulse for an undefined opcode
//   busy                   : instruction in flight
module vector_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned NUM_LANES       = 8,
   parameter int unsigned LANES_PER_CYCLE = 4,
   parameter int unsigned OP_W            = 4,
   localparam int unsigned BEATS          = NUM_LANES / LANES_PER_CYCLE,
   localparam int unsigned BW             = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic [OP_W-1:0]      op,
   input  logic                 cond,
   input  logic                 stall,
   output logic                 ctrl_valid,
   output logic [BW-1:0]        beat_idx,
   output logic                 last_beat,
   output logic [NUM_LANES-1:0] lane_mask,
   output logic                 get8,
   output logic                 pc_src,
   output logic                 scalar_write,
   output logic                 vector_write,
   output logic                 histogram_write,
   output logic                 mem_to_reg,
   output logic                 mem_write,
   output logic                 branch,
   output logic                 hist_src,
   output logic                 flag_write,
   output logic                 imm_src,
   output logic                 vector_or_histogram,
   output logic [2:0]           alu_control,
   output logic [2:0]           lane_control,
   output logic                 illegal_op,
   output logic                 busy
);

   seq_state_e           state_q, state_d;
   logic [BW-1:0]        beat_q, beat_d;
   logic                 vec_q, vec_d;
   ctrl_word_t           ctrl_q, ctrl_d;
   logic                 valid_q, valid_d;
   logic                 last_q, last_d;
   logic [NUM_LANES-1:0] mask_q, mask_d;
   logic                 illegal_q, illegal_d;
   logic                 load_c;
   logic                 accept_c;
   decode_t              dec_c;
   logic [NUM_LANES-1:0] gen_mask_c;

   // Mask for the beat that will be live next cycle.
   lane_mask_gen #(
      .NUM_LANES       (NUM_LANES),
      .LANES_PER_CYCLE (LANES_PER_CYCLE)
   ) u_lane_mask_gen (
      .beat_idx (beat_d),
      .mask_c   (gen_mask_c)
   );

   // Ready on idle, or on an unstalled final beat for zero-bubble issue.
   // The bubble carries last_beat=0, so it never accepts.
   assign instr_ready = (state_q == ST_IDLE) || (valid_q && last_q && !stall);
   assign accept_c    = instr_valid && instr_ready;
   assign dec_c       = decode_op(SEQ_OP_W'(op), cond);

   // State register (plus registered control word and framing).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         beat_q    <= '0;
         vec_q     <= 1'b0;
         ctrl_q    <= CTRL_NOP;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         mask_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         vec_q     <= vec_d;
         ctrl_q    <= ctrl_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         mask_q    <= mask_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state: beat sequencing and instruction load.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      vec_d   = vec_q;
      load_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) load_c = 1'b1;
         end
         ST_ISSUE: begin
            if (!stall) begin
               if (last_q) begin
                  if (accept_c) begin
                     load_c = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                     beat_d  = '0;
                     vec_d   = 1'b0;
                  end
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end
         end
         ST_BUBBLE: begin
            state_d = ST_IDLE;
            beat_d  = '0;
            vec_d   = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            beat_d  = '0;
            vec_d   = 1'b0;
         end
      endcase
      if (load_c) begin
         state_d = (dec_c.cls == CLS_ILLEGAL) ? ST_BUBBLE : ST_ISSUE;
         beat_d  = '0;
         vec_d   = (dec_c.cls == CLS_VECTOR);
      end
   end

   // Output next-values; a stalled beat recomputes to the same values.
   always_comb begin
      ctrl_d    = ctrl_q;
      valid_d   = valid_q;
      illegal_d = 1'b0;
      if (load_c) begin
         valid_d = 1'b1;
         if (dec_c.cls == CLS_ILLEGAL) begin
            ctrl_d    = CTRL_NOP;
            illegal_d = 1'b1;
         end else begin
            ctrl_d = dec_c.ctrl;
         end
      end else if (state_d == ST_IDLE) begin
         ctrl_d  = CTRL_NOP;
         valid_d = 1'b0;
      end
      last_d = (state_d == ST_ISSUE) && (!vec_d || (beat_d == BW'(BEATS - 1)));
      if (state_d == ST_ISSUE) begin
         mask_d = vec_d ? gen_mask_c : '1;
      end else begin
         mask_d = '0;
      end
   end

   assign ctrl_valid          = valid_q;
   assign beat_idx            = beat_q;
   assign last_beat           = last_q;
   assign lane_mask           = mask_q;
   assign illegal_op          = illegal_q;
   assign busy                = (state_q != ST_IDLE);
   assign get8                = ctrl_q.get8;
   assign pc_src              = ctrl_q.pc_src;
   assign scalar_write        = ctrl_q.scalar_write;
   assign vector_write        = ctrl_q.vector_write;
   assign histogram_write     = ctrl_q.histogram_write;
   assign mem_to_reg          = ctrl_q.mem_to_reg;
   assign mem_write           = ctrl_q.mem_write;
   assign branch              = ctrl_q.branch;
   assign hist_src            = ctrl_q.hist_src;
   assign flag_write          = ctrl_q.flag_write;
   assign imm_src             = ctrl_q.imm_src;
   assign vector_or_histogram = ctrl_q.vector_or_histogram;
   assign alu_control         = ctrl_q.alu_control;
   assign lane_control        = ctrl_q.lane_control;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: an 8-lane/4-per-beat instance and a
// 16-lane/4-per-beat instance, hand-computed expectations.
module tb_vector_sequencer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 8-lane instance
   logic       instr_valid, instr_ready, cond, stall;
   logic [3:0] op;
   logic       ctrl_valid, last_beat, illegal_op, busy;
   logic [0:0] beat_idx;
   logic [7:0] lane_mask;
   logic       get8, pc_src, scalar_write, vector_write, histogram_write, mem_to_reg;
   logic       mem_write, branch, hist_src, flag_write, imm_src, vector_or_histogram;
   logic [2:0] alu_control, lane_control;

   vector_sequencer #(.NUM_LANES(8), .LANES_PER_CYCLE(4), .OP_W(4)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .op(op), .cond(cond), .stall(stall), .ctrl_valid(ctrl_valid), .beat_idx(beat_idx),
      .last_beat(last_beat), .lane_mask(lane_mask), .get8(get8), .pc_src(pc_src),
      .scalar_write(scalar_write), .vector_write(vector_write),
      .histogram_write(histogram_write), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
      .branch(branch), .hist_src(hist_src), .flag_write(flag_write), .imm_src(imm_src),
      .vector_or_histogram(vector_or_histogram), .alu_control(alu_control),
      .lane_control(lane_control), .illegal_op(illegal_op), .busy(busy)
   );

   // 16-lane instance
   logic        v16, r16, cond16, stall16;
   logic [3:0]  op16;
   logic        cv16, last16, ill16, busy16;
   logic [1:0]  beat16;
   logic [15:0] mask16;
   logic        g16, pcs16, sw16, vw16, hw16, m2r16, mw16, br16, hs16, fw16, imm16, voh16;
   logic [2:0]  alu16, lane16;

   vector_sequencer #(.NUM_LANES(16), .LANES_PER_CYCLE(4), .OP_W(4)) dut16 (
      .clk(clk), .reset(reset), .instr_valid(v16), .instr_ready(r16),
      .op(op16), .cond(cond16), .stall(stall16), .ctrl_valid(cv16), .beat_idx(beat16),
      .last_beat(last16), .lane_mask(mask16), .get8(g16), .pc_src(pcs16),
      .scalar_write(sw16), .vector_write(vw16), .histogram_write(hw16),
      .mem_to_reg(m2r16), .mem_write(mw16), .branch(br16), .hist_src(hs16),
      .flag_write(fw16), .imm_src(imm16), .vector_or_histogram(voh16),
      .alu_control(alu16), .lane_control(lane16), .illegal_op(ill16), .busy(busy16)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Strobes packed as {get8,pc_src,sw,vw,hw,m2r,mw,br,hs,fw,imm,voh}
   logic [11:0] strobes;
   assign strobes = {get8, pc_src, scalar_write, vector_write, histogram_write, mem_to_reg,
                     mem_write, branch, hist_src, flag_write, imm_src, vector_or_histogram};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single beat of the 8-lane instance.
   task automatic check_beat(input string tag, input logic [11:0] s, input logic [2:0] alu,
                             input logic [2:0] lane, input logic [7:0] m,
                             input logic b, input logic l);
      check({tag, ".valid"}, 32'(ctrl_valid), 32'd1);
      check({tag, ".strobes"}, 32'(strobes), 32'(s));
      check({tag, ".alu"}, 32'(alu_control), 32'(alu));
      check({tag, ".lane"}, 32'(lane_control), 32'(lane));
      check({tag, ".mask"}, 32'(lane_mask), 32'(m));
      check({tag, ".beat"}, 32'(beat_idx), 32'(b));
      check({tag, ".last"}, 32'(last_beat), 32'(l));
      check({tag, ".busy"}, 32'(busy), 32'd1);
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".valid"}, 32'(ctrl_valid), 32'd0);
      check({tag, ".strobes"}, 32'(strobes), 32'd0);
      check({tag, ".alu"}, 32'(alu_control), 32'd3);
      check({tag, ".lane"}, 32'(lane_control), 32'd7);
      check({tag, ".mask"}, 32'(lane_mask), 32'd0);
      check({tag, ".last"}, 32'(last_beat), 32'd0);
      check({tag, ".busy"}, 32'(busy), 32'd0);
      check({tag, ".ready"}, 32'(instr_ready), 32'd1);
      check({tag, ".ill"}, 32'(illegal_op), 32'd0);
   endtask

   localparam logic [11:0] S_ADD   = 12'b0010_0000_0010;
   localparam logic [11:0] S_LOAD  = 12'b0001_0100_0000;
   localparam logic [11:0] S_STORE = 12'b0000_0010_0000;
   localparam logic [11:0] S_MULS  = 12'b0000_1000_0000;
   localparam logic [11:0] S_NORM  = 12'b0000_1000_1001;
   localparam logic [11:0] S_BNQ0  = 12'b0000_0001_0010;
   localparam logic [11:0] S_BNQ1  = 12'b0100_0001_0010;
   localparam logic [11:0] S_MODS  = 12'b0001_0000_0000;

   initial begin
      reset = 1'b1;
      instr_valid = 1'b0; op = 4'd0; cond = 1'b0; stall = 1'b0;
      v16 = 1'b0; op16 = 4'd0; cond16 = 1'b0; stall16 = 1'b0;
      step();
      step();
      check_idle("reset");
      reset = 1'b0;
      step();

      // ADD: one beat, then idle
      instr_valid = 1'b1; op = 4'b0010;
      step();
      instr_valid = 1'b0;
      check_beat("add", S_ADD, 3'b000, 3'b111, 8'hFF, 1'b0, 1'b1);
      check("add.ready", 32'(instr_ready), 32'd1);
      step();
      check_idle("add_done");

      // LOAD then MULS back to back
      instr_valid = 1'b1; op = 4'b0110;
      step();
      check_beat("load0", S_LOAD, 3'b011, 3'b111, 8'h0F, 1'b0, 1'b0);
      check("load0.ready", 32'(instr_ready), 32'd0);
      op = 4'b1011;
      step();
      check_beat("load1", S_LOAD, 3'b011, 3'b111, 8'hF0, 1'b1, 1'b1);
      check("load1.ready", 32'(instr_ready), 32'd1);
      step();
      instr_valid = 1'b0;
      check_beat("muls0", S_MULS, 3'b011, 3'b010, 8'h0F, 1'b0, 1'b0);
      step();
      check_beat("muls1", S_MULS, 3'b011, 3'b010, 8'hF0, 1'b1, 1'b1);
      step();
      check_idle("muls_done");

      // STORE with 3 stall cycles on beat 0
      instr_valid = 1'b1; op = 4'b0111;
      step();
      instr_valid = 1'b0; stall = 1'b1;
      check_beat("store0", S_STORE, 3'b011, 3'b111, 8'h0F, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_beat("store0_hold", S_STORE, 3'b011, 3'b111, 8'h0F, 1'b0, 1'b0);
         check("store0_hold.ready", 32'(instr_ready), 32'd0);
      end
      stall = 1'b0;
      step();
      check_beat("store1", S_STORE, 3'b011, 3'b111, 8'hF0, 1'b1, 1'b1);

      // Stall on the last beat blocks the pending NORM
      stall = 1'b1; instr_valid = 1'b1; op = 4'b1010;
      #1;
      check("laststall.ready", 32'(instr_ready), 32'd0);
      step();
      check_beat("store1_hold", S_STORE, 3'b011, 3'b111, 8'hF0, 1'b1, 1'b1);
      stall = 1'b0;
      #1;
      check("laststall_rel.ready", 32'(instr_ready), 32'd1);
      step();
      instr_valid = 1'b0;
      check_beat("norm0", S_NORM, 3'b011, 3'b000, 8'h0F, 1'b0, 1'b0);
      step();
      check_beat("norm1", S_NORM, 3'b011, 3'b000, 8'hF0, 1'b1, 1'b1);
      step();
      check_idle("norm_done");

      // BNQ cond=0 then cond=1 back to back
      instr_valid = 1'b1; op = 4'b0101; cond = 1'b0;
      step();
      cond = 1'b1;
      check_beat("bnq0", S_BNQ0, 3'b101, 3'b111, 8'hFF, 1'b0, 1'b1);
      step();
      instr_valid = 1'b0; cond = 1'b0;
      check_beat("bnq1", S_BNQ1, 3'b101, 3'b111, 8'hFF, 1'b0, 1'b1);
      step();
      check_idle("bnq_done");

      // Illegal opcode bubble, stall ignored
      instr_valid = 1'b1; op = 4'b1101; stall = 1'b1;
      step();
      instr_valid = 1'b0;
      check("ill.valid", 32'(ctrl_valid), 32'd1);
      check("ill.pulse", 32'(illegal_op), 32'd1);
      check("ill.strobes", 32'(strobes), 32'd0);
      check("ill.busy", 32'(busy), 32'd1);
      check("ill.ready", 32'(instr_ready), 32'd0);
      step();
      stall = 1'b0;
      check_idle("ill_done");

      // Async reset during beat 1 of LOAD
      instr_valid = 1'b1; op = 4'b0110;
      step();
      instr_valid = 1'b0;
      step();
      check("rst_mid.beat", 32'(beat_idx), 32'd1);
      reset = 1'b1;
      #1;
      check_idle("rst_mid");
      step();
      reset = 1'b0;
      step();
      check_idle("rst_rel");

      // 16-lane MODS: four beats
      v16 = 1'b1; op16 = 4'b1000;
      step();
      v16 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         logic [15:0] m;
         m = 16'h000F << (4 * k);
         check("m16.valid", 32'(cv16), 32'd1);
         check("m16.vw", 32'(vw16), 32'd1);
         check("m16.mask", 32'(mask16), 32'(m));
         check("m16.beat", 32'(beat16), 32'(k));
         check("m16.last", 32'(last16), (k == 3) ? 32'd1 : 32'd0);
         step();
      end
      check("m16_done.valid", 32'(cv16), 32'd0);
      check("m16_done.mask", 32'(mask16), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- Multi-cycle, parametrised successor to the single-cycle opcode decoder.
- Accepts one 4-bit opcode per handshake and registers the decoded control word.
- Scalar and branch ops issue as one beat. Vector/histogram ops issue as NUM_LANES/LANES_PER_CYCLE consecutive beats, each with a lane mask.
- Sits between instruction fetch/decode and the scalar, vector and histogram datapaths. Supports stall back-pressure.

Parameters:
- NUM_LANES, 8, total vector lanes.
- LANES_PER_CYCLE, 4, lanes processed per beat; must divide NUM_LANES. Derived: BEATS = NUM_LANES/LANES_PER_CYCLE, BW = max(1, clog2(BEATS)).
- OP_W, 4, opcode width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  op/cond valid.
- instr_ready  out  1  sequencer can accept.
- op  in  OP_W  opcode.
- cond  in  1  branch condition (BNQ), sampled at accept.
- stall  in  1  datapath back-pressure; holds current beat.
- ctrl_valid  out  1  control word below is live this cycle.
- beat_idx  out  BW  current beat number.
- last_beat  out  1  final beat of the instruction.
- lane_mask  out  NUM_LANES  lanes active this beat.
- get8, pc_src, scalar_write, vector_write, histogram_write, mem_to_reg, mem_write, branch, hist_src, flag_write, imm_src, vector_or_histogram  out  1 each  control strobes.
- alu_control  out  3  ALU op.
- lane_control  out  3  lane-unit op.
- illegal_op  out  1  one-cycle pulse for an undefined opcode.
- busy  out  1  instruction in flight.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0, except alu_control=3'b011, lane_control=3'b111 and instr_ready=1. Reset mid-instruction abandons the instruction immediately.
- Handshake: accept when instr_valid && instr_ready. The control word is registered; beat 0 appears with ctrl_valid=1 on the cycle after accept.
- instr_ready = (state==IDLE) || (ctrl_valid && last_beat && !stall). This allows back-to-back issue with zero bubbles.
- FSM states:
  - IDLE: on accept, go to ISSUE with beat=0.
  - ISSUE: if stall, hold every output unchanged. Else if last_beat, go to IDLE, or reload ISSUE with beat=0 on a fresh accept. Else beat+1.
  - BUBBLE: illegal opcode. Lasts 1 cycle with ctrl_valid=1, all strobes 0, illegal_op=1, then go to IDLE. stall is ignored in BUBBLE.
- busy=1 in ISSUE and BUBBLE.
- Beat count: scalar/branch classes use 1 beat (beat_idx=0, last_beat=1, lane_mask all ones). Vector class uses BEATS beats; beat k has lane_mask bits [k*LANES_PER_CYCLE +: LANES_PER_CYCLE] set. When BEATS=1, the vector class behaves as a single beat with all lanes enabled.
- Write and store strobes (scalar_write, vector_write, histogram_write, mem_write, flag_write) are only ever 1 while ctrl_valid=1.
- Decode table. Defaults: all strobes 0, alu 011, lane_ctrl 111. Listed fields override the defaults.
  - MOV 1110: scalar_write, imm_src, alu 100.
  - INC 0001: scalar_write, alu 001.
  - ADD 0010: scalar_write, imm_src, alu 000.
  - CMP 0011: flag_write, alu 010.
  - B 0100: branch, pc_src=1, imm_src, alu 100.
  - BNQ 0101: branch, pc_src=cond latched at accept, imm_src, alu 101.
  - LOAD_8X8 0110 (vector): vector_write, mem_to_reg.
  - STORE_8X8 0111 (vector): mem_write.
  - MODS_8X8 1000 (vector): vector_write.
  - INC1_4X16 1001 (vector): histogram_write, vector_or_histogram, lane_ctrl 100.
  - NORM_4X16 1010 (vector): histogram_write, hist_src, vector_or_histogram, lane_ctrl 000.
  - MULS_4X16 1011 (vector): histogram_write, lane_ctrl 010.
  - GET8X8 1100 (vector): get8, vector_write, vector_or_histogram.
  - 0000, 1101, 1111: illegal.
- Stall on the last beat: instr_ready stays 0 and no accept occurs.
- If stall is asserted in IDLE it has no effect; accepts still occur.

Decomposition:
- Shared package seq_pkg holds:
  - an opcode enum (OP_MOV…OP_GET8X8);
  - a ctrl_word_t packed struct of all strobes plus alu_control and lane_control;
  - a CTRL_NOP constant;
  - an op-class enum {CLS_SCALAR, CLS_VECTOR, CLS_ILLEGAL};
  - a pure function decode_op(op, cond) returning {class, ctrl_word_t}.
- One sub-module, lane_mask_gen (beat index to lane mask), parametrised by NUM_LANES and LANES_PER_CYCLE.

Test Plan:
- Reset in the middle of a vector op (beat 1) -> the next cycle shows all outputs 0, alu 011, lane_ctrl 111, instr_ready=1.
- ADD accepted at cycle 0 -> cycle 1: ctrl_valid=1, scalar_write=1, imm_src=1, alu 000, lane_mask 8'hFF, last_beat=1; cycle 2: ctrl_valid=0.
- LOAD_8X8 (defaults) -> beats at cycles 1–2 with lane_mask 8'h0F then 8'hF0, vector_write=1, mem_to_reg=1; MUL accepted at cycle 2 appears at cycle 3 with no bubble.
- STORE_8X8 with stall=1 on beat 0 for 3 cycles -> beat 0 (lane_mask 8'h0F, mem_write=1) is held 4 cycles, then beat 1; instr_ready=0 throughout.
- BNQ with cond=0, then BNQ with cond=1 -> pc_src=0 then 1, branch=1 on both, alu 101.
- op=4'b1101 -> one cycle with ctrl_valid=1, illegal_op=1 and all strobes 0; NUM_LANES=16, LANES_PER_CYCLE=4 -> MODS produces 4 beats with masks 000F, 00F0, 0F00, F000.
